// File: rtl/aquisicao_peso.sv
// Load-cell acquisition: bit-banged 24-bit ADC frame reader, gram conversion, stability
// detector and per-product weight capture. Define PESO_MEDIA_EN for a 4-sample moving average.
module aquisicao_peso #(
    parameter int DIV_SCK   = 4,
    parameter int SHIFT     = 8,
    parameter int TOL       = 2,
    parameter int N_ESTAVEL = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        adc_dout,
    output logic        adc_sck,
    input  logic [1:0]  produto,
    input  logic        capturar,
    output logic [10:0] peso_atual,
    output logic        amostra_valida,
    output logic        estavel,
    output logic [10:0] peso_banana,
    output logic [10:0] peso_maracuja,
    output logic [10:0] peso_tangerina
);

    typedef enum logic [1:0] {OCIOSO, SCK_ALTO, SCK_BAIXO, PROCESSA} estado_t;

    localparam int CW = (DIV_SCK > 2) ? $clog2(DIV_SCK) : 1;
    localparam int EW = $clog2(N_ESTAVEL + 1);
    localparam logic [CW-1:0] ULTIMO = CW'(DIV_SCK - 1);

    estado_t        estado;
    logic [CW-1:0]  cnt;
    logic [4:0]     bit_cnt;
    logic [23:0]    shreg;
    logic [EW-1:0]  cnt_est;

    logic [23:0]    deslocado;
    logic [10:0]    convertido;
    logic [10:0]    filtrado;
    logic [10:0]    dif;
    logic [EW-1:0]  proximo_cnt;

    // Negative codes read as an empty scale; codes beyond 11 bits clip to full scale.
    always_comb begin
        deslocado = shreg >> SHIFT;
        if (shreg[23])
            convertido = '0;
        else if (deslocado > 24'd2047)
            convertido = 11'd2047;
        else
            convertido = deslocado[10:0];
    end

`ifdef PESO_MEDIA_EN
    logic [2:0][10:0] hist;
    logic [12:0]      soma;

    always_comb begin
        soma     = 13'(convertido) + 13'(hist[0]) + 13'(hist[1]) + 13'(hist[2]);
        filtrado = soma[12:2];
    end
`else
    assign filtrado = convertido;
`endif

    always_comb begin
        dif = (filtrado >= peso_atual) ? (filtrado - peso_atual) : (peso_atual - filtrado);
        if (dif <= 11'(TOL))
            proximo_cnt = (cnt_est == EW'(N_ESTAVEL)) ? cnt_est : cnt_est + EW'(1);
        else
            proximo_cnt = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado         <= OCIOSO;
            adc_sck        <= 1'b0;
            cnt            <= '0;
            bit_cnt        <= '0;
            shreg          <= '0;
            cnt_est        <= '0;
            peso_atual     <= '0;
            amostra_valida <= 1'b0;
            estavel        <= 1'b0;
            peso_banana    <= '0;
            peso_maracuja  <= '0;
            peso_tangerina <= '0;
`ifdef PESO_MEDIA_EN
            hist           <= '0;
`endif
        end else begin
            amostra_valida <= 1'b0;
            unique case (estado)
                OCIOSO: begin
                    adc_sck <= 1'b0;
                    cnt     <= '0;
                    bit_cnt <= '0;
                    if (!adc_dout) begin
                        estado  <= SCK_ALTO;
                        adc_sck <= 1'b1;
                    end
                end
                SCK_ALTO: begin
                    if (cnt == ULTIMO) begin
                        cnt     <= '0;
                        adc_sck <= 1'b0;
                        estado  <= SCK_BAIXO;
                        // The 25th pulse only selects gain 128 / channel A.
                        if (bit_cnt < 5'd24)
                            shreg <= {shreg[22:0], adc_dout};
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                SCK_BAIXO: begin
                    if (cnt == ULTIMO) begin
                        cnt     <= '0;
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd24) begin
                            estado <= PROCESSA;
                        end else begin
                            estado  <= SCK_ALTO;
                            adc_sck <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                PROCESSA: begin
                    peso_atual     <= filtrado;
                    amostra_valida <= 1'b1;
                    cnt_est        <= proximo_cnt;
                    estavel        <= (proximo_cnt == EW'(N_ESTAVEL));
`ifdef PESO_MEDIA_EN
                    hist           <= {hist[1:0], convertido};
`endif
                    estado         <= OCIOSO;
                end
                default: estado <= OCIOSO;
            endcase

            // Reads the registered weight, so a capture on an update edge keeps the old value.
            if (capturar && estavel) begin
                unique case (produto)
                    2'b01:   peso_banana    <= peso_atual;
                    2'b10:   peso_maracuja  <= peso_atual;
                    2'b11:   peso_tangerina <= peso_atual;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aquisicao_peso.sv
// Bench for aquisicao_peso: an ADC serial model drives frames and queues hand-computed
// expectations; a negedge monitor pops them on each amostra_valida and checks sck timing.
module tb_aquisicao_peso;

    localparam int DIV = 4;

    logic        clk;
    logic        rst;
    logic        adc_dout;
    logic        adc_sck;
    logic [1:0]  produto;
    logic        capturar;
    logic [10:0] peso_atual;
    logic        amostra_valida;
    logic        estavel;
    logic [10:0] peso_banana;
    logic [10:0] peso_maracuja;
    logic [10:0] peso_tangerina;

    int checks   = 0;
    int failures = 0;

    logic [11:0] exp_q[$];

    aquisicao_peso #(
        .DIV_SCK(DIV), .SHIFT(8), .TOL(2), .N_ESTAVEL(4)
    ) dut (
        .clk(clk), .rst(rst), .adc_dout(adc_dout), .adc_sck(adc_sck),
        .produto(produto), .capturar(capturar), .peso_atual(peso_atual),
        .amostra_valida(amostra_valida), .estavel(estavel),
        .peso_banana(peso_banana), .peso_maracuja(peso_maracuja),
        .peso_tangerina(peso_tangerina)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pops, one-cycle valid, pulse count and high-phase width.
    int   hi_run = 0;
    int   pulses = 0;
    logic prev_sck = 1'b0;
    logic prev_valid = 1'b0;
    logic [11:0] e;

    always @(negedge clk) begin
        if (rst) begin
            hi_run = 0;
            pulses = 0;
            prev_sck = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (adc_sck && !prev_sck) pulses++;
            if (adc_sck) hi_run++;
            else if (hi_run != 0) begin
                check("sck_high_cycles", hi_run, DIV);
                hi_run = 0;
            end
            prev_sck = adc_sck;
            if (prev_valid) check("valid_one_cycle", amostra_valida, 0);
            if (amostra_valida) begin
                check("sck_pulses", pulses, 25);
                pulses = 0;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_sample actual=%0d expected=none", peso_atual);
                end else begin
                    e = exp_q.pop_front();
                    check("peso_atual", peso_atual, e[10:0]);
                    check("estavel", estavel, e[11]);
                end
            end
            prev_valid = amostra_valida;
        end
    end

    task automatic wait_sck(input logic lvl);
        int n = 0;
        while (adc_sck !== lvl && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (adc_sck !== lvl) begin
            checks++;
            failures++;
            $display("FAIL sck_timeout actual=%0b expected=%0b", adc_sck, lvl);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL sample_timeout actual=%0d pending expected=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Serial ADC model: data changes after sck rises, the DUT samples late in the high phase.
    task automatic send_frame(input logic [23:0] raw, input logic [10:0] ep, input logic ee,
                              input bit cap, input logic [1:0] cprod);
        exp_q.push_back({ee, ep});
        adc_dout = 1'b0;
        for (int i = 0; i < 25; i++) begin
            wait_sck(1'b1);
            adc_dout = (i < 24) ? raw[23 - i] : 1'b1;
            wait_sck(1'b0);
        end
        if (cap) begin
            // Lands capturar on the same edge that updates peso_atual.
            repeat (4) @(negedge clk);
            produto  = cprod;
            capturar = 1'b1;
            @(negedge clk);
            capturar = 1'b0;
            produto  = 2'b00;
        end
        wait_drain();
    endtask

    task automatic capture(input logic [1:0] p);
        @(negedge clk);
        produto  = p;
        capturar = 1'b1;
        @(negedge clk);
        capturar = 1'b0;
        produto  = 2'b00;
        @(negedge clk);
    endtask

    task automatic check_regs(input logic [10:0] b, input logic [10:0] m, input logic [10:0] t);
        check("peso_banana", peso_banana, b);
        check("peso_maracuja", peso_maracuja, m);
        check("peso_tangerina", peso_tangerina, t);
    endtask

    task automatic check_zero();
        check("rst_adc_sck", adc_sck, 0);
        check("rst_peso_atual", peso_atual, 0);
        check("rst_amostra_valida", amostra_valida, 0);
        check("rst_estavel", estavel, 0);
        check_regs(11'd0, 11'd0, 11'd0);
    endtask

    initial begin
        logic [23:0] raw_abort;
        int hi;
        rst = 1'b1;
        adc_dout = 1'b1;
        capturar = 1'b0;
        produto = 2'b00;
        repeat (3) @(negedge clk);
        check_zero();
        rst = 1'b0;
        @(negedge clk);

        send_frame(24'h003E80, 11'd62, 1'b0, 1'b0, 2'b00);
        send_frame(24'h800000, 11'd0, 1'b0, 1'b0, 2'b00);
        send_frame(24'h7FFFFF, 11'd2047, 1'b0, 1'b0, 2'b00);

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++)
            send_frame(24'h01F400, 11'd500, (i == 4), 1'b0, 2'b00);

        capture(2'b10);
        check_regs(11'd0, 11'd500, 11'd0);
        capture(2'b00);
        check_regs(11'd0, 11'd500, 11'd0);
        capture(2'b11);
        check_regs(11'd0, 11'd500, 11'd500);

        send_frame(24'h01F800, 11'd504, 1'b0, 1'b1, 2'b01);
        check_regs(11'd500, 11'd500, 11'd500);
        capture(2'b10);
        check_regs(11'd500, 11'd500, 11'd500);

        // Abort a frame after its 12th pulse.
        raw_abort = 24'h01F400;
        adc_dout = 1'b0;
        for (int i = 0; i < 12; i++) begin
            wait_sck(1'b1);
            adc_dout = raw_abort[23 - i];
            wait_sck(1'b0);
        end
        rst = 1'b1;
        adc_dout = 1'b1;
        @(negedge clk);
        check_zero();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        send_frame(24'h003E80, 11'd62, 1'b0, 1'b0, 2'b00);

        hi = 0;
        repeat (60) begin
            @(negedge clk);
            if (adc_sck) hi++;
        end
        check("idle_hold_sck", hi, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        failures++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
